// File: rtl/axi_sram_rd_slave_pkg.sv
// Shared constants, FSM state type and burst-address helpers for the
// AXI4 read-only SRAM responder.
package axi_sram_rd_slave_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_4B     = 3'b010;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StData
  } state_e;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Address of the beat following addr; WRAP stays inside the (len+1)*4 byte block.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [7:0]  len,
                                            input logic [1:0]  burst);
    logic [31:0] mask;
    mask = (({24'b0, len} + 32'd1) << 2) - 32'd1;
    case (burst)
      BURST_FIXED: return addr;
      BURST_WRAP:  return (addr & ~mask) | ((addr + 32'd4) & mask);
      default:     return addr + 32'd4;
    endcase
  endfunction

endpackage

// File: rtl/axi_sram_rd_slave_lfsr16.sv
// 16-bit Galois-equivalent Fibonacci LFSR (x^16+x^14+x^13+x^11+1), stepping
// every cycle, loaded with the seed on synchronous reset.
module axi_sram_rd_slave_lfsr16 (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] out
);

  logic feedback;

  assign feedback = out[0] ^ out[2] ^ out[3] ^ out[5];

  // Right-shifting register; feedback enters at the top bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      out <= seed;
    end else begin
      out <= {feedback, out[15:1]};
    end
  end

endmodule

// File: rtl/axi_sram_rd_slave.sv
// AXI4 read-only responder serving FIXED/INCR/WRAP bursts from an internal
// word array, one outstanding transaction, configurable first-beat latency.
// Build option: define RANDOM_DELAY_EN to add LFSR-driven extra first-beat
// latency (0-3 cycles) and occasional one-cycle gaps between beats.
module axi_sram_rd_slave
  import axi_sram_rd_slave_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clock,
  input  logic        reset,
  output logic        arready_o,
  input  logic        arvalid_i,
  input  logic [31:0] araddr_i,
  input  logic [3:0]  arid_i,
  input  logic [7:0]  arlen_i,
  input  logic [2:0]  arsize_i,
  input  logic [1:0]  arburst_i,
  input  logic        rready_i,
  output logic        rvalid_o,
  output logic [1:0]  rresp_o,
  output logic [31:0] rdata_o,
  output logic        rlast_o,
  output logic [3:0]  rid_o
);

  localparam int unsigned IdxW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SpanBytes = 32'(DEPTH_WORDS * 4);

  logic [31:0] mem [DEPTH_WORDS];

  // Array starts zeroed.
  initial begin
    for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[IdxW'(i)] = '0;
  end

  state_e      state_q;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [1:0]  burst_q;
  logic        cfg_err_q;
  logic [7:0]  beat_q;
  logic [31:0] wait_q;

  logic        ar_hs;
  logic        r_hs;
  logic        cfg_err_in;
  logic        cur_cfg_err;
  logic [7:0]  cur_len;
  logic [31:0] step_addr;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_off;
  logic [IdxW-1:0] fetch_idx;
  logic        fetch_err;
  logic [7:0]  fetch_beat;
  logic [31:0] beat_data;
  logic [1:0]  beat_resp;
  logic        beat_last;
  logic [31:0] extra_wait;
  logic        gap;
  logic [31:0] first_wait;

`ifdef RANDOM_DELAY_EN
  logic [15:0] lfsr;

  axi_sram_rd_slave_lfsr16 u_lfsr (
    .clock (clock),
    .reset (reset),
    .seed  (16'hACE1),
    .out   (lfsr)
  );

  assign extra_wait = {30'b0, lfsr[1:0]};
  assign gap        = lfsr[2];
`else
  assign extra_wait = '0;
  assign gap        = 1'b0;
`endif

  assign ar_hs      = arvalid_i & arready_o;
  assign r_hs       = rvalid_o & rready_i;
  assign first_wait = 32'(LATENCY) + extra_wait;

  assign cfg_err_in = (arsize_i != SIZE_4B) || (arburst_i == 2'b11) ||
                      ((arburst_i == BURST_WRAP) && !wrap_len_ok(arlen_i));

  assign step_addr  = next_addr(addr_q, len_q, burst_q);

  // Select the address/beat number of whichever beat gets loaded this cycle.
  always_comb begin
    fetch_addr  = addr_q;
    fetch_beat  = beat_q;
    cur_len     = len_q;
    cur_cfg_err = cfg_err_q;
    unique case (state_q)
      StIdle: begin
        fetch_addr  = araddr_i;
        fetch_beat  = 8'd0;
        cur_len     = arlen_i;
        cur_cfg_err = cfg_err_in;
      end
      StData: begin
        fetch_addr = step_addr;
        fetch_beat = beat_q + 8'd1;
      end
      default: ;
    endcase
  end

  // Per-beat range check; offset wraps for addresses below the base.
  assign fetch_off = fetch_addr - ADDR_BASE;
  assign fetch_idx = fetch_off[IdxW+1:2];
  assign fetch_err = cur_cfg_err || (fetch_off >= SpanBytes);
  assign beat_data = fetch_err ? 32'd0 : mem[fetch_idx];
  assign beat_resp = fetch_err ? RESP_SLVERR : RESP_OKAY;
  assign beat_last = (fetch_beat == cur_len);

  // Burst FSM with registered AR/R outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      cfg_err_q <= 1'b0;
      beat_q    <= '0;
      wait_q    <= '0;
      arready_o <= 1'b0;
      rvalid_o  <= 1'b0;
      rresp_o   <= '0;
      rdata_o   <= '0;
      rlast_o   <= 1'b0;
      rid_o     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          arready_o <= 1'b1;
          if (ar_hs) begin
            arready_o <= 1'b0;
            addr_q    <= araddr_i;
            len_q     <= arlen_i;
            burst_q   <= arburst_i;
            cfg_err_q <= cfg_err_in;
            rid_o     <= arid_i;
            beat_q    <= 8'd0;
            if (first_wait == 32'd0) begin
              state_q  <= StData;
              rvalid_o <= 1'b1;
              rdata_o  <= beat_data;
              rresp_o  <= beat_resp;
              rlast_o  <= beat_last;
            end else begin
              state_q <= StWait;
              wait_q  <= first_wait - 32'd1;
            end
          end
        end
        StWait: begin
          if (wait_q == 32'd0) begin
            state_q  <= StData;
            rvalid_o <= 1'b1;
            rdata_o  <= beat_data;
            rresp_o  <= beat_resp;
            rlast_o  <= beat_last;
          end else begin
            wait_q <= wait_q - 32'd1;
          end
        end
        StData: begin
          if (r_hs) begin
            if (rlast_o) begin
              state_q   <= StIdle;
              arready_o <= 1'b1;
              rvalid_o  <= 1'b0;
              rlast_o   <= 1'b0;
            end else begin
              addr_q <= step_addr;
              beat_q <= beat_q + 8'd1;
              if (gap) begin
                // Zero-length wait: one rvalid-low cycle, then reload from addr_q.
                state_q  <= StWait;
                wait_q   <= 32'd0;
                rvalid_o <= 1'b0;
              end else begin
                rdata_o <= beat_data;
                rresp_o <= beat_resp;
                rlast_o <= beat_last;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_rd_slave.sv
// Directed, table-driven bench for axi_sram_rd_slave (default build, LATENCY 2).
module tb_axi_sram_rd_slave;
  import axi_sram_rd_slave_pkg::*;

  localparam int unsigned Depth = 4096;
  localparam int NumVec = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        arready_o;
  logic        arvalid_i = 1'b0;
  logic [31:0] araddr_i = '0;
  logic [3:0]  arid_i = '0;
  logic [7:0]  arlen_i = '0;
  logic [2:0]  arsize_i = SIZE_4B;
  logic [1:0]  arburst_i = BURST_INCR;
  logic        rready_i = 1'b1;
  logic        rvalid_o;
  logic [1:0]  rresp_o;
  logic [31:0] rdata_o;
  logic        rlast_o;
  logic [3:0]  rid_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0]       addr;
    logic [7:0]        len;
    logic [1:0]        burst;
    logic [2:0]        size;
    logic [3:0]        id;
    logic [15:0][31:0] data;
    logic [15:0][1:0]  resp;
  } vec_t;

  vec_t  vecs [NumVec];
  string names [NumVec];

  axi_sram_rd_slave dut (
    .clock     (clock),
    .reset     (reset),
    .arready_o (arready_o),
    .arvalid_i (arvalid_i),
    .araddr_i  (araddr_i),
    .arid_i    (arid_i),
    .arlen_i   (arlen_i),
    .arsize_i  (arsize_i),
    .arburst_i (arburst_i),
    .rready_i  (rready_i),
    .rvalid_o  (rvalid_o),
    .rresp_o   (rresp_o),
    .rdata_o   (rdata_o),
    .rlast_o   (rlast_o),
    .rid_o     (rid_o)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] pat(input int unsigned i);
    return (i == 0) ? 32'hDEAD_BEEF : 32'hA500_0000 + i;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [2:0] size,
                              input logic [3:0] id);
    vec_t v;
    v       = '0;
    v.addr  = addr;
    v.len   = len;
    v.burst = burst;
    v.size  = size;
    v.id    = id;
    return v;
  endfunction

  task automatic send_ar(input vec_t v, input string name);
    int k;
    arvalid_i = 1'b1;
    araddr_i  = v.addr;
    arid_i    = v.id;
    arlen_i   = v.len;
    arsize_i  = v.size;
    arburst_i = v.burst;
    k = 0;
    while (!arready_o && k < 10) begin
      tick();
      k++;
    end
    chk({name, " arready"}, 32'(arready_o), 32'd1);
    tick();
    arvalid_i = 1'b0;
  endtask

  task automatic wait_rvalid(input string name);
    int lat;
    lat = 0;
    while (!rvalid_o && lat < 20) begin
      tick();
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'd2);
  endtask

  task automatic check_beat(input vec_t v, input int b, input string name);
    chk($sformatf("%s b%0d rvalid", name, b), 32'(rvalid_o), 32'd1);
    chk($sformatf("%s b%0d rdata", name, b), rdata_o, v.data[b]);
    chk($sformatf("%s b%0d rresp", name, b), 32'(rresp_o), 32'(v.resp[b]));
    chk($sformatf("%s b%0d rlast", name, b), 32'(rlast_o), 32'(b == int'(v.len)));
    chk($sformatf("%s b%0d rid", name, b), 32'(rid_o), 32'(v.id));
  endtask

  task automatic run_vec(input vec_t v, input string name);
    send_ar(v, name);
    wait_rvalid(name);
    for (int b = 0; b <= int'(v.len); b++) begin
      check_beat(v, b, name);
      tick();
    end
    chk({name, " rvalid after"}, 32'(rvalid_o), 32'd0);
    chk({name, " arready after"}, 32'(arready_o), 32'd1);
  endtask

  initial begin
    vec_t v;

    // Preload after the DUT's own zero-fill at time 0.
    #1;
    for (int unsigned i = 0; i < Depth; i++) dut.mem[12'(i)] = pat(i);

    // Single-beat read of word 0.
    vecs[0] = mk(32'h8000_0000, 8'd0, BURST_INCR, SIZE_4B, 4'd3);
    vecs[0].data[0] = 32'hDEAD_BEEF;
    names[0] = "incr1";
    // INCR 4 beats from word 4.
    vecs[1] = mk(32'h8000_0010, 8'd3, BURST_INCR, SIZE_4B, 4'd5);
    for (int b = 0; b < 4; b++) vecs[1].data[b] = pat(4 + b);
    names[1] = "incr4";
    // WRAP 4 beats starting mid-block: 6,7,4,5.
    vecs[2] = mk(32'h8000_0018, 8'd3, BURST_WRAP, SIZE_4B, 4'd7);
    vecs[2].data[0] = pat(6);
    vecs[2].data[1] = pat(7);
    vecs[2].data[2] = pat(4);
    vecs[2].data[3] = pat(5);
    names[2] = "wrap4";
    // Below the window: two SLVERR beats with zero data.
    vecs[3] = mk(32'h0000_0000, 8'd1, BURST_INCR, SIZE_4B, 4'd1);
    vecs[3].resp[0] = RESP_SLVERR;
    vecs[3].resp[1] = RESP_SLVERR;
    names[3] = "oor";
    // Illegal size.
    vecs[4] = mk(32'h8000_0000, 8'd0, BURST_INCR, 3'b001, 4'd2);
    vecs[4].resp[0] = RESP_SLVERR;
    names[4] = "size";
    // FIXED repeats word 2.
    vecs[5] = mk(32'h8000_0008, 8'd2, BURST_FIXED, SIZE_4B, 4'd9);
    for (int b = 0; b < 3; b++) vecs[5].data[b] = pat(2);
    names[5] = "fixed3";
    // Unaligned start: low bits ignored, OKAY.
    vecs[6] = mk(32'h8000_0006, 8'd1, BURST_INCR, SIZE_4B, 4'd4);
    vecs[6].data[0] = pat(1);
    vecs[6].data[1] = pat(2);
    names[6] = "unalign";
    // Last word then one past the end.
    vecs[7] = mk(32'h8000_3FFC, 8'd1, BURST_INCR, SIZE_4B, 4'd6);
    vecs[7].data[0] = pat(4095);
    vecs[7].resp[1] = RESP_SLVERR;
    names[7] = "endcross";
    // WRAP with 3 beats is illegal.
    vecs[8] = mk(32'h8000_0000, 8'd2, BURST_WRAP, SIZE_4B, 4'd8);
    for (int b = 0; b < 3; b++) vecs[8].resp[b] = RESP_SLVERR;
    names[8] = "wrap3";
    // Reserved burst type.
    vecs[9] = mk(32'h8000_0000, 8'd0, 2'b11, SIZE_4B, 4'd15);
    vecs[9].resp[0] = RESP_SLVERR;
    names[9] = "burst11";

    // Reset state.
    repeat (3) tick();
    chk("reset arready", 32'(arready_o), 32'd0);
    chk("reset rvalid", 32'(rvalid_o), 32'd0);
    chk("reset rlast", 32'(rlast_o), 32'd0);
    chk("reset rdata", rdata_o, 32'd0);
    chk("reset rresp", 32'(rresp_o), 32'd0);
    chk("reset rid", 32'(rid_o), 32'd0);
    reset = 1'b0;
    tick();
    chk("release arready", 32'(arready_o), 32'd1);

    for (int i = 0; i < NumVec; i++) run_vec(vecs[i], names[i]);

    // Backpressure on beat 1: outputs hold, nothing lost or repeated.
    send_ar(vecs[1], "stall");
    wait_rvalid("stall");
    check_beat(vecs[1], 0, "stall");
    tick();
    rready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_beat(vecs[1], 1, $sformatf("stall c%0d", c));
      tick();
    end
    rready_i = 1'b1;
    for (int b = 1; b < 4; b++) begin
      check_beat(vecs[1], b, "stall");
      tick();
    end
    chk("stall rvalid after", 32'(rvalid_o), 32'd0);

    // Reset mid-burst aborts it; a fresh read then works.
    v = mk(32'h8000_0010, 8'd3, BURST_INCR, SIZE_4B, 4'd9);
    for (int b = 0; b < 4; b++) v.data[b] = pat(4 + b);
    send_ar(v, "abort");
    wait_rvalid("abort");
    check_beat(v, 0, "abort");
    tick();
    check_beat(v, 1, "abort");
    tick();
    reset = 1'b1;
    tick();
    chk("abort rvalid", 32'(rvalid_o), 32'd0);
    chk("abort arready", 32'(arready_o), 32'd0);
    reset = 1'b0;
    tick();
    chk("abort release arready", 32'(arready_o), 32'd1);
    v = mk(32'h8000_0040, 8'd0, BURST_INCR, SIZE_4B, 4'd12);
    v.data[0] = pat(16);
    run_vec(v, "post");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog in case a task loop misbehaves.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
